// File: rtl/run_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : run_sequencer
//  Description : Host-side run controller for a core with start/done pins.
//                For each accepted command it loads a byte image into data
//                memory, releases the core and counts cycles until done or
//                timeout, then drains a result window out of data memory.
//  Revision    : 1.0  initial release
// ============================================================================
module run_sequencer #(
    parameter int AW        = 8,
    parameter int CW        = 16,
    parameter int TIMEOUT   = 4096,
    parameter int LOAD_BASE = 0,
    parameter int RES_BASE  = 0
) (
    input  logic          clk,
    input  logic          start,
    input  logic          go,
    input  logic [AW-1:0] load_len,
    input  logic [AW-1:0] res_len,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          mem_sel,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          mem_we,
    input  logic [7:0]    mem_rdata,
    output logic          core_start,
    input  logic          core_done,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic [CW-1:0] cycles,
    output logic          timeout
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_RUN   = 2'd2;
    localparam logic [1:0] c_DRAIN = 2'd3;

    localparam logic [AW-1:0] c_LOAD_BASE = AW'(LOAD_BASE);
    localparam logic [AW-1:0] c_RES_BASE  = AW'(RES_BASE);
    localparam logic [AW-1:0] c_ONE       = AW'(1);
    localparam logic [CW-1:0] c_CYC_ONE   = CW'(1);
    // Cycle count value seen on the last permitted RUN cycle.
    localparam logic [CW-1:0] c_TMO_LAST  = CW'(TIMEOUT - 1);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic [AW-1:0] r_ptr;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] r_load_len;
    logic [AW-1:0] r_res_len;
    logic [CW-1:0] r_cycles;
    logic          r_timeout;

    // ------------------------------------------------------------------------
    // Handshake and exit qualifiers
    // ------------------------------------------------------------------------
    logic w_go_accept;
    logic w_load_xfer;
    logic w_load_last;
    logic w_drain_xfer;
    logic w_drain_last;
    logic w_run_tmo;
    logic w_run_exit;
    logic w_drain_skip;

    // Go only counts in IDLE, so a strobe while busy is dropped.
    assign w_go_accept  = (r_state == c_IDLE) && go;
    assign w_load_xfer  = (r_state == c_LOAD) && in_valid;
    // The current transfer is the final byte when cnt+1 reaches the length.
    assign w_load_last  = ((r_cnt + c_ONE) == r_load_len);
    assign w_drain_xfer = (r_state == c_DRAIN) && out_ready;
    assign w_drain_last = ((r_cnt + c_ONE) == r_res_len);
    // Done has priority over the timeout when both land on the same cycle.
    assign w_run_tmo    = (r_state == c_RUN) && !core_done && (r_cycles == c_TMO_LAST);
    assign w_run_exit   = (r_state == c_RUN) && (core_done || (r_cycles == c_TMO_LAST));
    assign w_drain_skip = (r_res_len == '0);

    // State register with synchronous reset back to IDLE.
    always_ff @(posedge clk) begin
        if (start) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (go) begin
                    w_next_state = (load_len != '0) ? c_LOAD : c_RUN;
                end
            end
            c_LOAD: begin
                if (w_load_xfer && w_load_last) begin
                    w_next_state = c_RUN;
                end
            end
            c_RUN: begin
                if (w_run_exit) begin
                    w_next_state = w_drain_skip ? c_IDLE : c_DRAIN;
                end
            end
            c_DRAIN: begin
                if (w_drain_xfer && w_drain_last) begin
                    w_next_state = c_IDLE;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // Pointer, counter, latched lengths and run statistics.
    always_ff @(posedge clk) begin
        if (start) begin
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_load_len <= '0;
            r_res_len  <= '0;
            r_cycles   <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_go_accept) begin
                // Lengths are frozen here; later input changes are ignored.
                r_load_len <= load_len;
                r_res_len  <= res_len;
                r_cycles   <= '0;
                r_timeout  <= 1'b0;
                r_ptr      <= c_LOAD_BASE;
                r_cnt      <= '0;
            end

            if (w_load_xfer || w_drain_xfer) begin
                // Pointer wraps naturally at 2**AW.
                r_ptr <= r_ptr + c_ONE;
                r_cnt <= r_cnt + c_ONE;
            end

            if (r_state == c_RUN) begin
                // The timeout cycle itself is not added to the count.
                if (w_run_tmo) begin
                    r_timeout <= 1'b1;
                end else begin
                    r_cycles <= r_cycles + c_CYC_ONE;
                end
                if (w_run_exit) begin
                    r_ptr <= c_RES_BASE;
                    r_cnt <= '0;
                end
            end
        end
    end

    // Output decode from registered state.
    always_comb begin
        in_ready   = 1'b0;
        mem_sel    = 1'b1;
        mem_addr   = r_ptr;
        mem_wdata  = in_data;
        mem_we     = 1'b0;
        core_start = 1'b1;
        out_data   = 8'd0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (r_state)
            c_IDLE: begin
                busy = 1'b0;
            end
            c_LOAD: begin
                in_ready = 1'b1;
                mem_we   = in_valid;
            end
            c_RUN: begin
                core_start = 1'b0;
                mem_sel    = 1'b0;
            end
            c_DRAIN: begin
                // Address is held by ptr, so out_data is stable under stall.
                out_valid = 1'b1;
                out_data  = mem_rdata;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign cycles  = r_cycles;
    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_run_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_run_sequencer
//  Description : Scoreboard bench for run_sequencer. One instance with
//                TIMEOUT=16 and LOAD_BASE=RES_BASE=254 so the load/drain
//                windows straddle the address wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_run_sequencer;

    localparam int AW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          start;
    logic          go;
    logic [AW-1:0] load_len;
    logic [AW-1:0] res_len;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          mem_sel;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_we;
    logic [7:0]    mem_rdata;
    logic          core_start;
    logic          core_done;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic [CW-1:0] cycles;
    logic          timeout;

    int total = 0;
    int bad   = 0;

    logic [15:0] wr_q[$];   // expected {addr, data} writes
    logic [7:0]  out_q[$];  // expected drained bytes

    logic [7:0] mem [0:255];
    int         run_cnt;
    int         done_at;    // 0 = core never finishes

    always #5 clk = ~clk;

    run_sequencer #(
        .AW(AW), .CW(CW), .TIMEOUT(16), .LOAD_BASE(254), .RES_BASE(254)
    ) dut (
        .clk(clk), .start(start), .go(go), .load_len(load_len), .res_len(res_len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata), .core_start(core_start),
        .core_done(core_done), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .cycles(cycles), .timeout(timeout)
    );

    // Data memory model: sequencer-side writes, combinational read.
    always @(posedge clk) begin
        if (mem_sel && mem_we) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    // Core model: PC counts while released, done on cycle number done_at.
    always @(posedge clk) begin
        if (core_start) run_cnt <= 0;
        else            run_cnt <= run_cnt + 1;
    end
    assign core_done = !core_start && (done_at != 0) && (run_cnt == done_at - 1);

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT completes a transfer.
    always @(negedge clk) begin
        if (!start && mem_sel && mem_we) begin
            check("we_only_on_xfer", int'(in_valid && in_ready), 1);
            if (wr_q.size() == 0) begin
                check("unexpected_write_addr", int'(mem_addr), -1);
            end else begin
                logic [15:0] e;
                e = wr_q.pop_front();
                check("write_addr", int'(mem_addr), int'(e[15:8]));
                check("write_data", int'(mem_wdata), int'(e[7:0]));
            end
        end
        if (!start && out_valid && out_ready) begin
            if (out_q.size() == 0) begin
                check("unexpected_out", int'(out_data), -1);
            end else begin
                logic [7:0] e;
                e = out_q.pop_front();
                check("out_data", int'(out_data), int'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int runs;
        int n;
        int hs;
        logic [7:0] d0;
        logic [7:0] bytes5 [4];

        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
        start = 1'b1; go = 1'b0; load_len = '0; res_len = '0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b1; done_at = 0;
        tick(); tick();
        start = 1'b0;

        // ---- Test 1: reset in the middle of RUN ----
        go = 1'b1; load_len = 8'd0; res_len = 8'd0;
        tick();
        go = 1'b0;
        check("t1_core_start_low_latency", int'(core_start), 0);
        repeat (4) tick();
        check("t1_cycles_before_reset", int'(cycles), 4);
        start = 1'b1;
        tick();
        check("t1_busy_after_reset", int'(busy), 0);
        check("t1_core_start_after_reset", int'(core_start), 1);
        tick();
        start = 1'b0;
        check("t1_mem_sel", int'(mem_sel), 1);
        check("t1_cycles", int'(cycles), 0);
        check("t1_timeout", int'(timeout), 0);
        check("t1_in_ready", int'(in_ready), 0);
        check("t1_out_valid", int'(out_valid), 0);
        check("t1_mem_we", int'(mem_we), 0);

        // ---- Tests 2+3: load 3 bytes with a gap, done on 5th cycle, drain 2 ----
        wr_q.push_back({8'd254, 8'd11});
        wr_q.push_back({8'd255, 8'd22});
        wr_q.push_back({8'd0,   8'd33});
        out_q.push_back(8'd11);
        out_q.push_back(8'd22);
        done_at = 5;
        go = 1'b1; load_len = 8'd3; res_len = 8'd2;
        tick();
        go = 1'b0; load_len = 8'd7; res_len = 8'd9;   // must be ignored
        check("t2_in_ready_latency", int'(in_ready), 1);
        in_valid = 1'b1; in_data = 8'd11; tick();
        in_valid = 1'b0; in_data = 8'd99; tick(); tick();
        check("t2_still_load_in_gap", int'(in_ready), 1);
        in_valid = 1'b1; in_data = 8'd22; tick();
        in_data = 8'd33; tick();
        in_valid = 1'b0;
        check("t2_core_start_run", int'(core_start), 0);
        check("t2_mem_sel_run", int'(mem_sel), 0);
        check("t2_in_ready_run", int'(in_ready), 0);
        runs = 0;
        while (mem_sel == 1'b0 && runs < 100) begin runs++; tick(); end
        check("t3_run_cycles_seen", runs, 5);
        check("t3_cycles", int'(cycles), 5);
        check("t3_timeout", int'(timeout), 0);
        check("t3_out_valid", int'(out_valid), 1);
        // Stall the consumer and strobe go while busy.
        out_ready = 1'b0; go = 1'b1; load_len = 8'd0; res_len = 8'd0;
        #1;
        d0 = out_data;
        check("t3_first_byte", int'(d0), 11);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_stall_valid", int'(out_valid), 1);
            check("t3_stall_stable", int'(out_data), int'(d0));
            check("t6_go_busy_ignored", int'(in_ready), 0);
        end
        go = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (busy && n < 20) begin n++; tick(); end
        check("t3_idle_after_drain", int'(busy), 0);
        check("t3_out_q_empty", out_q.size(), 0);
        check("t2_wr_q_empty", wr_q.size(), 0);

        // ---- Test 4: core never finishes, timeout after 16 RUN cycles ----
        done_at = 0;
        out_q.push_back(8'd11);
        go = 1'b1; load_len = 8'd0; res_len = 8'd1;
        tick();
        go = 1'b0;
        runs = 0;
        while (mem_sel == 1'b0 && runs < 100) begin runs++; tick(); end
        check("t4_run_cycles_seen", runs, 16);
        check("t4_timeout", int'(timeout), 1);
        check("t4_cycles", int'(cycles), 15);
        check("t4_drain_valid", int'(out_valid), 1);
        n = 0;
        while (busy && n < 20) begin n++; tick(); end
        check("t4_idle", int'(busy), 0);
        check("t4_timeout_sticky", int'(timeout), 1);

        // ---- Test 5: load window wraps 254,255,0,1 ----
        bytes5[0] = 8'hA1; bytes5[1] = 8'hB2; bytes5[2] = 8'hC3; bytes5[3] = 8'hD4;
        wr_q.push_back({8'd254, 8'hA1});
        wr_q.push_back({8'd255, 8'hB2});
        wr_q.push_back({8'd0,   8'hC3});
        wr_q.push_back({8'd1,   8'hD4});
        out_q.push_back(8'hA1);
        out_q.push_back(8'hB2);
        out_q.push_back(8'hC3);
        done_at = 2;
        go = 1'b1; load_len = 8'd4; res_len = 8'd3;
        tick();
        go = 1'b0;
        check("t4_go_clears_timeout", int'(timeout), 0);
        check("t5_go_clears_cycles", int'(cycles), 0);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = bytes5[i]; tick();
        end
        in_valid = 1'b0;
        runs = 0;
        while (mem_sel == 1'b0 && runs < 100) begin runs++; tick(); end
        check("t5_run_cycles_seen", runs, 2);
        check("t5_cycles", int'(cycles), 2);
        n = 0;
        while (busy && n < 20) begin n++; tick(); end
        check("t5_idle", int'(busy), 0);
        check("t5_wr_q_empty", wr_q.size(), 0);
        check("t5_out_q_empty", out_q.size(), 0);

        // ---- Test 6: zero-length load and drain ----
        done_at = 3;
        go = 1'b1; load_len = 8'd0; res_len = 8'd0;
        tick();
        go = 1'b0;
        check("t6_core_start_latency", int'(core_start), 0);
        runs = 0; hs = 0;
        while (busy && runs < 50) begin
            if (in_ready || out_valid) hs++;
            runs++;
            tick();
        end
        check("t6_run_cycles_seen", runs, 3);
        check("t6_no_handshakes", hs, 0);
        check("t6_idle", int'(busy), 0);
        check("t6_core_held", int'(core_start), 1);
        check("t6_cycles", int'(cycles), 3);

        tick();
        check("end_wr_q_empty", wr_q.size(), 0);
        check("end_out_q_empty", out_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
